// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package rca_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // A single-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/addsub4_slice.sv
// Combinational 4-bit ripple-carry add/sub: s = a + (b ^ ctrl) + cin.
module addsub4_slice
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic                ctrl,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   c;

  assign bx   = b ^ {NIBBLE_W{ctrl}};
  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/rca_serial_seq.sv
// Wide add/sub by time-multiplexing one 4-bit slice, LS nibble first.
// Optional zero flag output enabled by RCA_SEQ_ZERO_FLAG_EN.
module rca_serial_seq
  import rca_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
`ifdef RCA_SEQ_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int            CW   = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic                 carry;
  logic [W-1:0]         a_q, b_q;
  logic                 sub_q;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, s_nib;
  logic                 c_nib;
  logic                 last;
`ifdef RCA_SEQ_ZERO_FLAG_EN
  logic                 zero_acc;
`endif

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt == CW'(k)) begin
        a_nib = a_q[NIBBLE_W*k +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*k +: NIBBLE_W];
      end
    end
  end

  assign last = (cnt == LAST);

  addsub4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .ctrl (sub_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (last)        state_nx = DONE;
      DONE:    if (done_ready)  state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
`ifdef RCA_SEQ_ZERO_FLAG_EN
      zero_acc <= 1'b0;
      zero     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub;
            carry <= sub;
            cnt   <= '0;
`ifdef RCA_SEQ_ZERO_FLAG_EN
            zero_acc <= 1'b1;
`endif
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (cnt == CW'(k)) result[NIBBLE_W*k +: NIBBLE_W] <= s_nib;
          end
          carry <= c_nib;
          cnt   <= cnt + 1'b1;
`ifdef RCA_SEQ_ZERO_FLAG_EN
          zero_acc <= zero_acc & (s_nib == '0);
`endif
          // The last nibble's MSB is the operand sign bit.
          if (last) begin
            cout <= c_nib;
            ovf  <= (a_nib[NIBBLE_W-1] == (b_nib[NIBBLE_W-1] ^ sub_q)) &&
                    (s_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
`ifdef RCA_SEQ_ZERO_FLAG_EN
            zero <= zero_acc & (s_nib == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
